// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: per-phase tick dwells, optional all-red
// clearance, latched pedestrian walk request and a night-flash override.
module traffic_light_ctrl #(
   parameter int CNT_W        = 8,
   parameter int GREEN_TICKS  = 5,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int WALK_TICKS   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic       ns_g,
   output logic       ns_y,
   output logic       ns_r,
   output logic       ew_g,
   output logic       ew_y,
   output logic       ew_r,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR1   = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR2   = 3'd5,
      WALK  = 3'd6,
      FLASH = 3'd7
   } state_t;

   localparam bit             HAS_AR = (ALLRED_TICKS != 0);
   localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(HAS_AR ? ALLRED_TICKS - 1 : 0);
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_TICKS - 1);

   // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
   function automatic logic [6:0] lamps_of(input state_t s, input logic fph);
      case (s)
         NS_G:    lamps_of = 7'b100_001_0;
         NS_Y:    lamps_of = 7'b010_001_0;
         EW_G:    lamps_of = 7'b001_100_0;
         EW_Y:    lamps_of = 7'b001_010_0;
         WALK:    lamps_of = 7'b001_001_1;
         FLASH:   lamps_of = {1'b0, fph, 3'b000, fph, 1'b0};
         default: lamps_of = 7'b001_001_0;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flash_ph_q, flash_ph_d;
   logic             ped_pending_q, ped_pending_d;
   logic [6:0]       lamps_q, lamps_d;

   state_t           after_clear;
   state_t           seq_next;
   logic [CNT_W-1:0] last;

   always_comb begin
      after_clear = ped_pending_q ? WALK : NS_G;

      last     = G_LAST;
      seq_next = NS_G;
      case (state_q)
         NS_G:    begin last = G_LAST; seq_next = NS_Y; end
         NS_Y:    begin last = Y_LAST; seq_next = HAS_AR ? AR1 : EW_G; end
         AR1:     begin last = A_LAST; seq_next = EW_G; end
         EW_G:    begin last = G_LAST; seq_next = EW_Y; end
         EW_Y:    begin last = Y_LAST; seq_next = HAS_AR ? AR2 : after_clear; end
         AR2:     begin last = A_LAST; seq_next = after_clear; end
         WALK:    begin last = W_LAST; seq_next = NS_G; end
         default: begin last = G_LAST; seq_next = NS_G; end
      endcase

      state_d    = state_q;
      cnt_d      = cnt_q;
      flash_ph_d = flash_ph_q;

      // Flash override beats any dwell tick in the same cycle.
      if (flash_en && state_q != FLASH) begin
         state_d    = FLASH;
         cnt_d      = '0;
         flash_ph_d = 1'b1;
      end else if (state_q == FLASH) begin
         if (flash_en) begin
            if (tick) flash_ph_d = ~flash_ph_q;
         end else begin
            state_d    = HAS_AR ? AR2 : after_clear;
            cnt_d      = '0;
            flash_ph_d = 1'b0;
         end
      end else if (tick) begin
         if (cnt_q == last) begin
            state_d = seq_next;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      ped_pending_d = ped_pending_q | (ped_req & (state_q != WALK));
      if (state_d == WALK && state_q != WALK) ped_pending_d = 1'b0;

      lamps_d = lamps_of(state_d, flash_ph_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= NS_G;
         cnt_q         <= '0;
         flash_ph_q    <= 1'b0;
         ped_pending_q <= 1'b0;
         lamps_q       <= 7'b100_001_0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         flash_ph_q    <= flash_ph_d;
         ped_pending_q <= ped_pending_d;
         lamps_q       <= lamps_d;
      end
   end

   assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} = lamps_q;
   assign ped_pending = ped_pending_q;
   assign phase       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: default, fast no-all-red and long-green builds
// driven from a shared stimulus and checked through an expected-value queue.
module tb_traffic_light_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0, tick = 1'b0, ped_req = 1'b0, flash_en = 1'b0;

   always #5 clk = ~clk;

   logic       a_ns_g, a_ns_y, a_ns_r, a_ew_g, a_ew_y, a_ew_r, a_walk, a_pend;
   logic [2:0] a_phase;
   logic       b_ns_g, b_ns_y, b_ns_r, b_ew_g, b_ew_y, b_ew_r, b_walk, b_pend;
   logic [2:0] b_phase;
   logic       c_ns_g, c_ns_y, c_ns_r, c_ew_g, c_ew_y, c_ew_r, c_walk, c_pend;
   logic [2:0] c_phase;

   traffic_light_ctrl dut_a (
      .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
      .ns_g(a_ns_g), .ns_y(a_ns_y), .ns_r(a_ns_r), .ew_g(a_ew_g), .ew_y(a_ew_y),
      .ew_r(a_ew_r), .walk(a_walk), .ped_pending(a_pend), .phase(a_phase));

   traffic_light_ctrl #(.GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(0)) dut_b (
      .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
      .ns_g(b_ns_g), .ns_y(b_ns_y), .ns_r(b_ns_r), .ew_g(b_ew_g), .ew_y(b_ew_y),
      .ew_r(b_ew_r), .walk(b_walk), .ped_pending(b_pend), .phase(b_phase));

   traffic_light_ctrl #(.CNT_W(8), .GREEN_TICKS(255)) dut_c (
      .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
      .ns_g(c_ns_g), .ns_y(c_ns_y), .ns_r(c_ns_r), .ew_g(c_ew_g), .ew_y(c_ew_y),
      .ew_r(c_ew_r), .walk(c_walk), .ped_pending(c_pend), .phase(c_phase));

   // Observed word: {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending}
   wire [10:0] obs_a = {a_phase, a_ns_g, a_ns_y, a_ns_r, a_ew_g, a_ew_y, a_ew_r, a_walk, a_pend};
   wire [10:0] obs_b = {b_phase, b_ns_g, b_ns_y, b_ns_r, b_ew_g, b_ew_y, b_ew_r, b_walk, b_pend};
   wire [10:0] obs_c = {c_phase, c_ns_g, c_ns_y, c_ns_r, c_ew_g, c_ew_y, c_ew_r, c_walk, c_pend};

   typedef struct {
      logic       r, t, p, f;
      logic [2:0] ph;
      logic       pend;
      logic       fph;
   } vec_t;

   vec_t        vecs[$];
   logic [10:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [6:0] lamp_of(input logic [2:0] ph, input logic fph);
      case (ph)
         3'd0:    lamp_of = 7'b1000010;
         3'd1:    lamp_of = 7'b0100010;
         3'd2:    lamp_of = 7'b0010010;
         3'd3:    lamp_of = 7'b0011000;
         3'd4:    lamp_of = 7'b0010100;
         3'd5:    lamp_of = 7'b0010010;
         3'd6:    lamp_of = 7'b0010011;
         default: lamp_of = {1'b0, fph, 3'b000, fph, 1'b0};
      endcase
   endfunction

   function automatic logic [10:0] exp_word(input logic [2:0] ph, input logic pend,
                                            input logic fph);
      exp_word = {ph, lamp_of(ph, fph), pend};
   endfunction

   function automatic void add(input logic r, input logic t, input logic p, input logic f,
                               input logic [2:0] ph, input logic pend, input logic fph);
      vec_t v;
      v.r = r; v.t = t; v.p = p; v.f = f; v.ph = ph; v.pend = pend; v.fph = fph;
      vecs.push_back(v);
   endfunction

   function automatic void add_ticks(input int n, input logic [2:0] ph, input logic pend);
      for (int i = 0; i < n; i++) add(0, 1, 0, 0, ph, pend, 0);
   endfunction

   // Starts and ends at a falling edge so outputs are sampled mid-cycle.
   task automatic cyc(input logic r, input logic t, input logic p, input logic f);
      rst = r; tick = t; ped_req = p; flash_en = f;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; tick = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
   endtask

   task automatic check_word(input string name, input int idx, input logic [10:0] got);
      logic [10:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got phase=%0d lamps=%b pend=%b, want phase=%0d lamps=%b pend=%b",
                  name, idx, got[10:8], got[7:1], got[0], exp[10:8], exp[7:1], exp[0]);
      end
   endtask

   function automatic logic [2:0] dflt_phase(input int n);
      int m;
      m = n % 16;
      if (m < 5)       dflt_phase = 3'd0;
      else if (m < 7)  dflt_phase = 3'd1;
      else if (m < 8)  dflt_phase = 3'd2;
      else if (m < 13) dflt_phase = 3'd3;
      else if (m < 15) dflt_phase = 3'd4;
      else             dflt_phase = 3'd5;
   endfunction

   function automatic logic [2:0] fast_phase(input int n);
      case (n % 4)
         0:       fast_phase = 3'd0;
         1:       fast_phase = 3'd1;
         2:       fast_phase = 3'd3;
         default: fast_phase = 3'd4;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nsg_cnt;

      // Pedestrian request during EW_G, walk service, ped_req ignored in WALK.
      add(1, 0, 0, 0, 0, 0, 0);
      add_ticks(4, 0, 0);
      add_ticks(2, 1, 0);
      add_ticks(1, 2, 0);
      add_ticks(1, 3, 0);
      add(0, 0, 1, 0, 3, 1, 0);
      add_ticks(4, 3, 1);
      add_ticks(2, 4, 1);
      add_ticks(1, 5, 1);
      add(0, 1, 1, 0, 6, 0, 0);
      add(0, 1, 1, 0, 6, 0, 0);
      add(0, 0, 1, 0, 6, 0, 0);
      add_ticks(2, 6, 0);
      add_ticks(1, 0, 0);

      // Flash entered with a coincident tick at cnt=3, then released.
      add(1, 0, 0, 0, 0, 0, 0);
      add_ticks(3, 0, 0);
      add(0, 1, 0, 1, 7, 0, 1);
      add(0, 0, 0, 1, 7, 0, 1);
      add(0, 1, 0, 1, 7, 0, 0);
      add(0, 1, 0, 1, 7, 0, 1);
      add(0, 0, 0, 0, 5, 0, 0);
      add_ticks(5, 0, 0);
      add_ticks(1, 1, 0);
      // Request latched while flashing survives and is served after AR2.
      add(0, 0, 0, 1, 7, 0, 1);
      add(0, 0, 1, 1, 7, 1, 1);
      add(0, 0, 0, 0, 5, 1, 0);
      add(0, 1, 0, 0, 6, 0, 0);

      // Reset mid EW_Y with a pending request, then a full NS green.
      add(1, 0, 0, 0, 0, 0, 0);
      add_ticks(4, 0, 0);
      add_ticks(2, 1, 0);
      add_ticks(1, 2, 0);
      add_ticks(1, 3, 0);
      add(0, 0, 1, 0, 3, 1, 0);
      add_ticks(4, 3, 1);
      add_ticks(2, 4, 1);
      add(1, 1, 0, 0, 0, 0, 0);
      add_ticks(4, 0, 0);
      add_ticks(1, 1, 0);

      @(negedge clk);
      foreach (vecs[i]) begin
         exp_q.push_back(exp_word(vecs[i].ph, vecs[i].pend, vecs[i].fph));
         cyc(vecs[i].r, vecs[i].t, vecs[i].p, vecs[i].f);
         check_word("vec", i, obs_a);
      end

      // Default build, tick every 4 clk: one full 16-tick cycle.
      cyc(1, 0, 0, 0);
      n = 0;
      nsg_cnt = 0;
      for (int k = 1; k <= 64; k++) begin
         if (k % 4 == 0) n++;
         exp_q.push_back(exp_word(dflt_phase(n), 1'b0, 1'b0));
         cyc(0, (k % 4 == 0), 0, 0);
         check_word("cycle", k, obs_a);
         if (a_ns_g) nsg_cnt++;
      end
      checks++;
      if (nsg_cnt != 20) begin
         errors++;
         $display("FAIL ns_g_clocks got %0d want 20", nsg_cnt);
      end

      // Fast no-all-red build and 255-tick green build, back-to-back ticks.
      cyc(1, 0, 0, 0);
      exp_q.push_back(exp_word(3'd0, 1'b0, 1'b0));
      check_word("fast_rst", 0, obs_b);
      exp_q.push_back(exp_word(3'd0, 1'b0, 1'b0));
      check_word("long_rst", 0, obs_c);
      for (int k = 1; k <= 255; k++) begin
         cyc(0, 1, 0, 0);
         if (k <= 24) begin
            exp_q.push_back(exp_word(fast_phase(k), 1'b0, 1'b0));
            check_word("fast", k, obs_b);
         end
         if (k >= 250) begin
            exp_q.push_back(exp_word((k < 255) ? 3'd0 : 3'd1, 1'b0, 1'b0));
            check_word("long", k, obs_c);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
